// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, frame types and parity helper.
// Also used by the UART transmitter (divisor, parity).
package uart_pkg;

  localparam int BAUD_DIV_DEFAULT = 868;
  localparam int DATA_BITS        = 8;
  localparam int FIFO_DEPTH       = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BRK_WAIT
  } rx_state_t;

  typedef struct packed {
    logic                 frame_err;
    logic                 parity_err;
    logic [DATA_BITS-1:0] data;
  } rx_frame_t;

  // Parity bit the sender puts on the line
  function automatic logic par(
    input logic [DATA_BITS-1:0] data,
    input logic                 odd
  );
    return ^data ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte valid/ready bundle with error flags.
// master = receiver side, slave = consumer side.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;

  modport master (
    output rx_data, rx_valid,
    output parity_err, frame_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid,
    input  parity_err, frame_err,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small frame FIFO behind the receiver FSM.
// DEPTH must be a power of two; caller never pushes when full w/o pop.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  rx_frame_t frame_i,
  input  logic      pop_i,
  output rx_frame_t frame_o,
  output logic      empty_o,
  output logic      full_o
);

  rx_frame_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W:0]   cnt_q;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign frame_o = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= frame_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, start + 8 data (LSB first) + parity + 1/2 stop.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter  int BAUD_DIVISOR = BAUD_DIV_DEFAULT,
  localparam int CNT_W        = $clog2(BAUD_DIVISOR)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx_in_i,
  input  logic      odd_parity_i,
  input  logic      two_stop_i,
  uart_rx_if.master rx_if,
  output logic      overrun_o,
  output logic      rx_busy_o
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(BAUD_DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BAUD_DIVISOR - 1);
  localparam logic [BIT_W-1:0] LAST = BIT_W'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rxs;
  rx_state_t            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 tick;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 odd_q;
  logic                 two_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 done_q;
  logic                 ovr_q;
  rx_frame_t            frm;

  assign rxs       = sync_q[1];
  assign tick      = (cnt_q == '0);
  assign rx_busy_o = (state_q != IDLE);
  assign frm       = {ferr_q, perr_q, shift_q};
  assign overrun_o = ovr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      odd_q   <= 1'b0;
      two_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_in_i};
      done_q <= 1'b0;
      if (!tick) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (!rxs) begin
            cnt_q   <= HALF;
            odd_q   <= odd_parity_i;
            two_q   <= two_stop_i;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            if (rxs) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= FULL;
              bit_q   <= '0;
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift_q[bit_q] <= rxs;
            cnt_q          <= FULL;
            bit_q          <= bit_q + BIT_W'(1);
            if (bit_q == LAST) begin
              state_q <= PARITY;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            perr_q  <= (rxs != par(shift_q, odd_q));
            ferr_q  <= 1'b0;
            cnt_q   <= FULL;
            state_q <= STOP1;
          end
        end
        STOP1: begin
          if (tick) begin
            ferr_q <= !rxs;
            cnt_q  <= FULL;
            if (two_q && rxs) begin
              state_q <= STOP2;
            end else begin
              done_q  <= 1'b1;
              state_q <= rxs ? IDLE : BRK_WAIT;
            end
          end
        end
        STOP2: begin
          if (tick) begin
            ferr_q  <= !rxs;
            done_q  <= 1'b1;
            state_q <= rxs ? IDLE : BRK_WAIT;
          end
        end
        BRK_WAIT: begin
          if (rxs) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  logic      f_empty;
  logic      f_full;
  logic      f_pop;
  logic      f_push;
  rx_frame_t head;

  // A pop in the same cycle frees the slot for a full-FIFO push
  assign f_pop  = !f_empty && rx_if.rx_ready;
  assign f_push = done_q && (!f_full || f_pop);

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (f_push),
    .frame_i(frm),
    .pop_i  (f_pop),
    .frame_o(head),
    .empty_o(f_empty),
    .full_o (f_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= done_q && f_full && !f_pop;
    end
  end

  assign rx_if.rx_valid   = !f_empty;
  assign rx_if.rx_data    = head.data;
  assign rx_if.parity_err = head.parity_err;
  assign rx_if.frame_err  = head.frame_err;
`else
  logic      valid_q;
  rx_frame_t out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done_q) begin
        if (!valid_q || rx_if.rx_ready) begin
          out_q   <= frm;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx_if.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_valid   = valid_q;
  assign rx_if.rx_data    = out_q.data;
  assign rx_if.parity_err = out_q.parity_err;
  assign rx_if.frame_err  = out_q.frame_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a queue model of delivered bytes.
// Build with UART_RX_FIFO_EN to exercise the FIFO variant.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BD  = 16;
  // line start -> output edge: 2 sync + detect + half bit + 10 bits + out reg
  localparam int LAT = 4 + BD / 2 + 10 * BD;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH   = 4;
  localparam int OVR_EXP = 1;
`else
  localparam int DEPTH   = 1;
  localparam int OVR_EXP = 4;
`endif

  typedef struct {
    int         due;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_in = 1'b1;
  logic odd_parity = 1'b0;
  logic two_stop = 1'b0;
  logic ready = 1'b0;
  logic overrun;
  logic rx_busy;

  uart_rx_if ifc ();
  assign ifc.rx_ready = ready;

  uart_rx #(
    .BAUD_DIVISOR(BD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in_i     (rx_in),
    .odd_parity_i(odd_parity),
    .two_stop_i  (two_stop),
    .rx_if       (ifc),
    .overrun_o   (overrun),
    .rx_busy_o   (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk = 0;
  int pass = 0;
  exp_t pend[$];
  exp_t mq[$];
  int last_e0 = 0;
  int cap_edge = 0;
  logic [7:0] cap_d = '0;
  logic cap_pe = 1'b0;
  logic cap_fe = 1'b0;
  int ovr_cnt = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    chk++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  task automatic send(input logic [7:0] d, input logic odd,
                      input logic two, input logic pbad,
                      input logic s1, input logic s2);
    logic [11:0] bits;
    logic p;
    int nb;
    exp_t e;
    p = 1'(($countones(d) % 2)) ^ odd ^ pbad;
    bits = {s2, s1, p, d, 1'b0};
    nb = two ? 12 : 11;
    @(posedge clk); #1;
    last_e0 = cyc;
    odd_parity = odd;
    two_stop = two;
    e.due = cyc + LAT + ((two && s1) ? BD : 0);
    e.d = d;
    e.pe = pbad;
    e.fe = !s1 || (two && !s2);
    pend.push_back(e);
    for (int i = 0; i < nb; i++) begin
      rx_in = bits[i];
      repeat (BD) @(posedge clk);
      #1;
    end
    rx_in = 1'b1;
  endtask

  // Model of the delivered-byte stream, checked every cycle
  initial begin
    logic rdy_s;
    logic rst_s;
    logic vq;
    logic m_ovr;
    exp_t e;
    int n;
    rdy_s = 1'b0;
    rst_s = 1'b1;
    vq = 1'b0;
    forever begin
      @(negedge clk);
      n = cyc;
      m_ovr = 1'b0;
      if (rst_s) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && rdy_s) void'(mq.pop_front());
        if (pend.size() > 0 && pend[0].due == n) begin
          e = pend.pop_front();
          if (mq.size() < DEPTH) mq.push_back(e);
          else m_ovr = 1'b1;
        end
      end
      check("rx_valid", ifc.rx_valid, mq.size() > 0);
      check("overrun", overrun, m_ovr);
      if (mq.size() > 0) begin
        check("rx_data", ifc.rx_data, mq[0].d);
        check("parity_err", ifc.parity_err, mq[0].pe);
        check("frame_err", ifc.frame_err, mq[0].fe);
      end
      if (overrun) ovr_cnt++;
      if (ifc.rx_valid && !vq) begin
        cap_edge = n;
        cap_d = ifc.rx_data;
        cap_pe = ifc.parity_err;
        cap_fe = ifc.frame_err;
      end
      vq = ifc.rx_valid;
      rdy_s = ready;
      rst_s = rst;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish by cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", ifc.rx_valid, 0);
    check("rst_data", ifc.rx_data, 0);
    check("rst_busy", rx_busy, 0);
    rst = 1'b0;
    ready = 1'b1;
    repeat (5) @(posedge clk);

    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("a5_lat", cap_edge - last_e0, 172);
    check("a5_data", cap_d, 8'hA5);
    check("a5_pe", cap_pe, 0);
    check("a5_fe", cap_fe, 0);

    send(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("3c_data", cap_d, 8'h3C);
    check("3c_pe", cap_pe, 1);
    check("3c_fe", cap_fe, 0);

    send(8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("81_lat", cap_edge - last_e0, 188);
    check("81_fe", cap_fe, 1);
    check("81_pe", cap_pe, 0);
    rx_in = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (20) @(posedge clk);

    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("55_lat", cap_edge - last_e0, 172);
    check("55_data", cap_d, 8'h55);

    @(posedge clk); #1;
    rx_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx_in = 1'b1;
    check("glitch_busy", rx_busy, 1);
    repeat (8) @(posedge clk);
    #1;
    check("glitch_idle", rx_busy, 0);
    repeat (200) @(posedge clk);

    ready = 1'b0;
    ovr_cnt = 0;
    send(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovr_count", ovr_cnt, OVR_EXP);
    check("ovr_held", ifc.rx_data, 8'h11);
    ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("drained", ifc.rx_valid, 0);

    ready = 1'b0;
    send(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    rx_in = 1'b0;
    repeat (3 * BD) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_valid", ifc.rx_valid, 0);
    check("mrst_data", ifc.rx_data, 0);
    check("mrst_pe", ifc.parity_err, 0);
    check("mrst_fe", ifc.frame_err, 0);
    check("mrst_ovr", overrun, 0);
    check("mrst_busy", rx_busy, 0);
    rst = 1'b0;
    rx_in = 1'b1;
    ready = 1'b1;
    repeat (20) @(posedge clk);

    send(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("0f_lat", cap_edge - last_e0, 172);
    check("0f_data", cap_d, 8'h0F);
    repeat (10) @(posedge clk);
    #1;
    check("pend_empty", pend.size(), 0);

    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
